// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment read-back monitor:
//   - segment byte patterns for digits 0..9 and the blank marker
//     (bit 7 = blank/DP, bits 6:0 = segments g..a, active-high)
//   - active-low digit-select encodings for the tens and units digits
//   - frame-assembly FSM state encoding
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h80;

    localparam logic [1:0] CAT_TENS  = 2'b10;
    localparam logic [1:0] CAT_UNITS = 2'b01;

    typedef enum logic {
        WAIT_TENS  = 1'b0,
        WAIT_UNITS = 1'b1
    } state_e;

endpackage

// File: rtl/seg_pattern_reader_if.sv
// ---------------------------------------------------------------------------
// seg_pattern_reader_if
// Bundles the multiplexed segment bus being monitored together with the
// reconstructed-value outputs of the reader.
//   sample_en   : single-cycle strobe, seg_in/cat valid on this cycle
//   seg_in[7:0] : segment byte (bit 7 blank/DP, bits 6:0 segments g..a)
//   cat[1:0]    : active-low digit select (2'b10 tens, 2'b01 units)
//   value[3:0]  : last published binary value
//   value_valid : one-cycle pulse when value is updated
//   err         : one-cycle pulse on a malformed sample or frame
//   err_cnt[7:0]: saturating error count (zero unless counter is built)
// master drives the bus and observes results; slave is the reader.
// ---------------------------------------------------------------------------
interface seg_pattern_reader_if;

    logic       sample_en;
    logic [7:0] seg_in;
    logic [1:0] cat;
    logic [3:0] value;
    logic       value_valid;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output sample_en, seg_in, cat,
        input  value, value_valid, err, err_cnt
    );

    modport slave (
        input  sample_en, seg_in, cat,
        output value, value_valid, err, err_cnt
    );

endinterface

// File: rtl/seg_pattern_to_digit.sv
// ---------------------------------------------------------------------------
// seg_pattern_to_digit
// Combinational lookup from a segment byte to the digit it displays.
//   pattern_i[7:0] : segment byte
//   ok_o           : 1 when the byte is exactly one of the digit patterns
//   digit_o[3:0]   : decoded digit 0..9 (0 when ok_o is low)
// Any byte with bit 7 set (blank marker) or an unlisted segment mix is
// reported as not ok.
// ---------------------------------------------------------------------------
module seg_pattern_to_digit
    import seg_pkg::*;
(
    input  logic [7:0] pattern_i,
    output logic       ok_o,
    output logic [3:0] digit_o
);

    always_comb begin
        ok_o    = 1'b1;
        digit_o = 4'd0;
        case (pattern_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: ok_o    = 1'b0;
            default:   ok_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_pattern_reader.sv
// ---------------------------------------------------------------------------
// seg_pattern_reader
// Monitors a multiplexed two-digit seven-segment bus, assembles tens/units
// frames, and publishes the represented 4-bit value (0..15) once the same
// valid value has been seen on STABLE_FRAMES consecutive frames.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_pattern_reader_if.slave (sample_en, seg_in, cat in;
//           value, value_valid, err, err_cnt out)
// Parameter STABLE_FRAMES (1..15, default 3): identical valid frames needed
// before a publish.
// Optional build macro SEG_READER_ERR_CNT_EN: when defined, err_cnt counts
// err pulses and saturates at 255; otherwise err_cnt is tied to zero.
// All outputs are registered.
// ---------------------------------------------------------------------------
module seg_pattern_reader
    import seg_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_pattern_reader_if.slave   bus
);

    localparam logic [3:0] STAB_MAX = STABLE_FRAMES[3:0];

    logic       dig_ok;
    logic [3:0] dig_val;

    seg_pattern_to_digit u_decode (
        .pattern_i (bus.seg_in),
        .ok_o      (dig_ok),
        .digit_o   (dig_val)
    );

    state_e     state_q,       state_d;
    logic [3:0] tens_dig_q,    tens_dig_d;
    logic       tens_ok_q,     tens_ok_d;
    logic [3:0] stab_cnt_q,    stab_cnt_d;
    logic [3:0] last_cand_q,   last_cand_d;
    logic       locked_q,      locked_d;
    logic [3:0] value_q,       value_d;
    logic       value_valid_q, value_valid_d;
    logic       err_q,         err_d;

    // Tens is only meaningful as 0 or 1, so the candidate only ever adds 10;
    // out-of-range tens digits are rejected by frame_ok regardless.
    logic [4:0] cand5;
    logic [3:0] cand;
    logic       frame_ok;

    assign cand5    = {1'b0, dig_val} + ((tens_dig_q == 4'd1) ? 5'd10 : 5'd0);
    assign cand     = cand5[3:0];
    assign frame_ok = tens_ok_q && dig_ok && (tens_dig_q <= 4'd1) && (cand5 <= 5'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_TENS;
            tens_dig_q    <= 4'd0;
            tens_ok_q     <= 1'b0;
            stab_cnt_q    <= 4'd0;
            last_cand_q   <= 4'd0;
            locked_q      <= 1'b0;
            value_q       <= 4'd0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tens_dig_q    <= tens_dig_d;
            tens_ok_q     <= tens_ok_d;
            stab_cnt_q    <= stab_cnt_d;
            last_cand_q   <= last_cand_d;
            locked_q      <= locked_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tens_dig_d    = tens_dig_q;
        tens_ok_d     = tens_ok_q;
        stab_cnt_d    = stab_cnt_q;
        last_cand_d   = last_cand_q;
        locked_d      = locked_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;

        if (bus.sample_en) begin
            if (bus.cat == CAT_TENS) begin
                // A tens sample always (re)starts a frame, in either state.
                tens_dig_d = dig_val;
                tens_ok_d  = dig_ok;
                state_d    = WAIT_UNITS;
            end else if (bus.cat == CAT_UNITS) begin
                // A units sample without a preceding tens is a silent resync.
                if (state_q == WAIT_UNITS) begin
                    state_d = WAIT_TENS;
                    if (!frame_ok) begin
                        err_d      = 1'b1;
                        stab_cnt_d = 4'd0;
                        locked_d   = 1'b0;
                    end else begin
                        if (cand == last_cand_q) begin
                            stab_cnt_d = (stab_cnt_q >= STAB_MAX) ? STAB_MAX
                                                                  : stab_cnt_q + 4'd1;
                        end else begin
                            last_cand_d = cand;
                            stab_cnt_d  = 4'd1;
                            locked_d    = 1'b0;
                        end
                        // locked_d already reflects a change of candidate.
                        if ((stab_cnt_d == STAB_MAX) && !locked_d) begin
                            value_d       = cand;
                            value_valid_d = 1'b1;
                            locked_d      = 1'b1;
                        end
                    end
                end
            end else begin
                // Both or neither digit selected: not a legal bus state.
                err_d      = 1'b1;
                state_d    = WAIT_TENS;
                stab_cnt_d = 4'd0;
                locked_d   = 1'b0;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = value_valid_q;
    assign bus.err         = err_q;

`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts alongside the err register so err_cnt moves with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg_pattern_reader.sv
module tb_seg_pattern_reader;
    import seg_pkg::*;

    logic clk;
    logic rst_n;

    seg_pattern_reader_if bus ();

    seg_pattern_reader #(
        .STABLE_FRAMES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int vv_pulses = 0;
    int both_high = 0;

`ifdef SEG_READER_ERR_CNT_EN
    localparam logic [7:0] ERR_CNT_SAT = 8'd255;
`else
    localparam logic [7:0] ERR_CNT_SAT = 8'd0;
`endif

    always @(negedge clk) begin
        if (bus.value_valid) vv_pulses++;
        if (bus.value_valid && bus.err) both_high++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample on the cycle after the next falling edge; returns on the
    // falling edge after the capturing rising edge, where outputs reflect it.
    task automatic sample(input logic [7:0] s, input logic [1:0] c);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.seg_in    = s;
        bus.cat       = c;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.seg_in    = 8'h00;
        bus.cat       = 2'b11;
    endtask

    // Tens and units on back-to-back cycles.
    task automatic frame(input logic [7:0] t, input logic [7:0] u);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.seg_in    = t;
        bus.cat       = CAT_TENS;
        @(negedge clk);
        bus.seg_in    = u;
        bus.cat       = CAT_UNITS;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.seg_in    = 8'h00;
        bus.cat       = 2'b11;
    endtask

    task automatic expect_out(input string tag, input logic vv, input logic e, input logic [3:0] v);
        check_eq({tag, "_vv"},    {31'd0, bus.value_valid}, {31'd0, vv});
        check_eq({tag, "_err"},   {31'd0, bus.err},         {31'd0, e});
        check_eq({tag, "_value"}, {28'd0, bus.value},       {28'd0, v});
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.seg_in    = 8'h00;
        bus.cat       = 2'b11;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 1'b0, 1'b0, 4'd0);
        check_eq("reset_errcnt", {24'd0, bus.err_cnt}, 32'd0);
        rst_n = 1'b1;

        // Value 3 needs three identical frames; a fourth stays silent.
        frame(SEG_0, SEG_3); expect_out("f3_1", 1'b0, 1'b0, 4'd0);
        frame(SEG_0, SEG_3); expect_out("f3_2", 1'b0, 1'b0, 4'd0);
        frame(SEG_0, SEG_3); expect_out("f3_3", 1'b1, 1'b0, 4'd3);
        @(negedge clk);      expect_out("f3_drop", 1'b0, 1'b0, 4'd3);
        frame(SEG_0, SEG_3); expect_out("f3_4", 1'b0, 1'b0, 4'd3);

        // 15 then 14.
        frame(SEG_1, SEG_5); expect_out("f15_1", 1'b0, 1'b0, 4'd3);
        frame(SEG_1, SEG_5); expect_out("f15_2", 1'b0, 1'b0, 4'd3);
        frame(SEG_1, SEG_5); expect_out("f15_3", 1'b1, 1'b0, 4'd15);
        frame(SEG_1, SEG_4); expect_out("f14_1", 1'b0, 1'b0, 4'd15);
        frame(SEG_1, SEG_4); expect_out("f14_2", 1'b0, 1'b0, 4'd15);
        frame(SEG_1, SEG_4); expect_out("f14_3", 1'b1, 1'b0, 4'd14);

        // 18 is out of range: err, value held, stability and lock cleared,
        // so the same 14 must be re-earned with three frames and republishes.
        frame(SEG_1, SEG_8); expect_out("f18", 1'b0, 1'b1, 4'd14);
        @(negedge clk);      expect_out("f18_drop", 1'b0, 1'b0, 4'd14);
        frame(SEG_1, SEG_4); expect_out("r14_1", 1'b0, 1'b0, 4'd14);
        frame(SEG_1, SEG_4); expect_out("r14_2", 1'b0, 1'b0, 4'd14);
        frame(SEG_1, SEG_4); expect_out("r14_3", 1'b1, 1'b0, 4'd14);

        // Leading units sample is ignored silently.
        sample(SEG_3, CAT_UNITS); expect_out("resync", 1'b0, 1'b0, 4'd14);
        frame(SEG_0, SEG_7); expect_out("f7_1", 1'b0, 1'b0, 4'd14);
        frame(SEG_0, SEG_7); expect_out("f7_2", 1'b0, 1'b0, 4'd14);
        frame(SEG_0, SEG_7); expect_out("f7_3", 1'b1, 1'b0, 4'd7);

        // Malformed inputs.
        frame(SEG_BLANK, SEG_0); expect_out("blank_tens", 1'b0, 1'b1, 4'd7);
        frame(SEG_0, SEG_BLANK); expect_out("blank_units", 1'b0, 1'b1, 4'd7);
        sample(SEG_0, 2'b11);    expect_out("cat11", 1'b0, 1'b1, 4'd7);
        sample(SEG_0, 2'b00);    expect_out("cat00", 1'b0, 1'b1, 4'd7);
        frame(SEG_2, SEG_0);     expect_out("tens2", 1'b0, 1'b1, 4'd7);

        // Tens, tens again, units: the second tens wins (cand 7, stab 1).
        sample(SEG_1, CAT_TENS);
        sample(SEG_0, CAT_TENS);
        sample(SEG_7, CAT_UNITS); expect_out("restart", 1'b0, 1'b0, 4'd7);

        // 300 back-to-back illegal selects.
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.seg_in    = SEG_0;
        bus.cat       = 2'b11;
        repeat (300) @(negedge clk);
        bus.sample_en = 1'b0;
        check_eq("err_burst", {31'd0, bus.err}, 32'd1);
        check_eq("err_cnt_sat", {24'd0, bus.err_cnt}, {24'd0, ERR_CNT_SAT});

        // Asynchronous reset between tens and units.
        frame(SEG_1, SEG_5);
        sample(SEG_1, CAT_TENS);
        check_eq("pre_rst_value", {28'd0, bus.value}, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 4'd0);
        check_eq("async_rst_errcnt", {24'd0, bus.err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(SEG_0, SEG_3); expect_out("post_1", 1'b0, 1'b0, 4'd0);
        frame(SEG_0, SEG_3); expect_out("post_2", 1'b0, 1'b0, 4'd0);
        frame(SEG_0, SEG_3); expect_out("post_3", 1'b1, 1'b0, 4'd3);
        @(negedge clk);

        check_eq("vv_pulse_total", vv_pulses, 32'd6);
        check_eq("vv_err_exclusive", both_high, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_pattern_reader.md
# seg_pattern_reader

Reads back a multiplexed two-digit seven-segment bus (segment byte plus active-low digit select) and reconstructs the 4-bit binary value 0–15 that the display encoding represents. It sits on the display side of the segment datapath as a self-check and loopback monitor. It also drives a stable binary result to downstream logic. A value is published only after it has been seen for a configurable number of consecutive identical frames.

## Interface
- STABLE_FRAMES, default 3: number of consecutive identical valid frames required before publishing; legal range 1–15.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  single-cycle strobe; seg_in and cat are stable and are sampled on this cycle.
- seg_in  input  8  bit 7 is the blank/DP marker (1 = blank); bits 6:0 are segments g..a, active-high.
- cat  input  2  active-low digit select; 2'b10 = tens digit, 2'b01 = units digit.
- value  output  4  last published binary value.
- value_valid  output  1  one-cycle pulse when value is updated.
- err  output  1  one-cycle pulse on a malformed sample or frame.
- err_cnt  output  8  saturating error count (see Configuration).

## Operation
- Pattern map, bit 7 = 0: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other byte, including 0x80 blank, is invalid.
- A frame is one tens sample followed by one units sample.
- FSM states are WAIT_TENS and WAIT_UNITS. The reset state is WAIT_TENS.
- WAIT_TENS:
  - A tens sample stores tens_dig and tens_ok, then moves to WAIT_UNITS.
  - A units sample is ignored (resync), with no err.
- WAIT_UNITS:
  - A tens sample overwrites tens_dig and tens_ok; the state stays WAIT_UNITS (the frame restarts).
  - A units sample completes the frame and returns to WAIT_TENS.
- cat of 2'b00 or 2'b11 with sample_en: err pulse, state goes to WAIT_TENS, stab_cnt is cleared to 0, locked is cleared.
- Frame check:
  - The frame is valid iff both digits are valid, tens ∈ {0,1}, and tens*10+units ≤ 15.
  - cand = tens*10+units, computed in 5 bits and truncated to 4 bits.
- Invalid frame: err pulse, stab_cnt=0, locked=0.
- Valid frame, cand equals last_cand: stab_cnt increments, saturating at STABLE_FRAMES.
- Valid frame, cand differs from last_cand: last_cand=cand, stab_cnt=1, locked=0.
- Publish: when stab_cnt becomes equal to STABLE_FRAMES and locked=0, then value<=cand, value_valid=1 for one cycle, and locked<=1.
- No further pulses occur while identical frames continue.
- With STABLE_FRAMES=1, every new differing valid frame publishes immediately.
- Reset values: value=0, value_valid=0, err=0, err_cnt=0, stab_cnt=0, last_cand=0, locked=0, tens_dig=0, tens_ok=0, state=WAIT_TENS.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- The completing units sample_en at cycle t produces value_valid / err at t+1. Both deassert at t+2 unless retriggered.
- value changes in the same cycle value_valid is high, and holds between publishes.
- Back-to-back sample_en on consecutive cycles is supported: one sample per cycle, no backpressure.
- err and value_valid are mutually exclusive in any cycle.
- Reset assertion mid-frame clears everything asynchronously. The first sample after release is treated as frame start.

## Configuration
- SEG_READER_ERR_CNT_EN defined: err_cnt increments on every err pulse, saturates at 255, and is cleared only by reset.
- Not defined: the counter logic is not built and err_cnt is tied to 8'h00. The port list is identical in both builds.

## Structure
- Package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK=8'h80;
  - cat encodings CAT_TENS=2'b10 and CAT_UNITS=2'b01;
  - FSM state encoding for WAIT_TENS and WAIT_UNITS.
- Sub-module seg_pattern_to_digit: combinational 8-bit pattern → {ok, digit[3:0]} lookup, instantiated once on seg_in.

## Test plan
- Reset, then 3 frames of tens 0x3F and units 0x4F → single value_valid with value=3 one cycle after the third units sample; a 4th identical frame produces no pulse.
- Frames 0x06/0x6D ×3, then 0x06/0x66 ×3 → publishes 15, then 14; each publish is one pulse.
- Frame 0x06/0x7F (tens 1, units 8 = 18) → err pulse, stab_cnt cleared, value unchanged.
- Units sample first, then a valid 0x3F/0x07 frame ×3 → leading units sample ignored with no err; value=7 published.
- Pattern 0x80 or cat=2'b11 → err pulse. With SEG_READER_ERR_CNT_EN, 300 errors leave err_cnt=255; without the macro, err_cnt stays 0.
- rst_n low between the tens and units samples of the second frame → all outputs 0 immediately; 3 further frames are needed to publish.
